// File: rtl/piso_serializer_if.sv
// Load handshake and serial output bundle for piso_serializer.
// master = word producer / serial consumer, slave = serializer.
interface piso_serializer_if #(
  parameter int WIDTH = 4
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             ser_out;
  logic             ser_en;
  logic             word_done;

  modport master (
    output load_valid,
    output load_data,
    input  load_ready,
    input  ser_out,
    input  ser_en,
    input  word_done
  );

  modport slave (
    input  load_valid,
    input  load_data,
    output load_ready,
    output ser_out,
    output ser_en,
    output word_done
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out stage, LSB first, with a one-entry
// input buffer so back-to-back words stream without gaps.
module piso_serializer #(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  piso_serializer_if.slave  bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] buf_data;
  logic             buf_full;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    cnt;

  logic accept;
  logic last;

  assign bus.load_ready = !rst && !buf_full;
  assign accept         = bus.load_valid && bus.load_ready;
  assign last           = (cnt == LAST);

  assign bus.ser_en    = (state == SHIFT);
  assign bus.ser_out   = (state == SHIFT) && sr[0];
  assign bus.word_done = (state == SHIFT) && last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      buf_data <= '0;
      buf_full <= 1'b0;
      sr       <= '0;
      cnt      <= '0;
    end else begin
      // accept only fires when the buffer is empty, so it
      // never collides with a drain below
      if (accept) begin
        buf_data <= bus.load_data;
        buf_full <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (buf_full) begin
            sr       <= buf_data;
            buf_full <= 1'b0;
            cnt      <= '0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (!last) begin
            sr  <= {1'b0, sr[WIDTH-1:1]};
            cnt <= cnt + CW'(1);
          end else if (buf_full) begin
            sr       <= buf_data;
            buf_full <= 1'b0;
            cnt      <= '0;
          end else begin
            sr    <= '0;
            cnt   <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: directed scenarios
// followed by randomized traffic with occasional resets.
module tb_piso_serializer;
  localparam int W = 4;

  typedef struct {
    int e;
    bit b;
    bit d;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  piso_serializer_if #(.WIDTH(W)) bus ();

  piso_serializer #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t         eq[$];
  logic [W-1:0] wq[$];
  int           checks = 0;
  int           errors = 0;
  int           k = 0;
  int           last_end = 0;
  int           acc_e = -1;
  int           start_e = -1;
  int           ne;
  int           ns;
  logic [W-1:0] dq = '0;
  logic [W-1:0] qexp;
  bit           qpend = 1'b0;
  bit           busy;
  exp_t         x;

  // downstream 4-bit register: new bit enters at the MSB
  always @(posedge clk) dq <= {bus.ser_out, dq[W-1:1]};

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h",
               nm, k, act, exp);
    end
  endtask

  // monitor + reference model; k counts edges seen so far
  always @(negedge clk) begin
    k++;
    if (qpend) begin
      chk("q_word", 32'(dq), 32'(qexp));
      qpend = 1'b0;
    end
    while (eq.size() > 0 && eq[0].e < k) begin
      checks++;
      errors++;
      $display("FAIL missed_bit cycle=%0d got=none want=%0d",
               k, eq[0].e);
      void'(eq.pop_front());
    end
    if (eq.size() > 0 && eq[0].e == k) begin
      x = eq.pop_front();
      chk("ser_en", 32'(bus.ser_en), 32'd1);
      chk("ser_out", 32'(bus.ser_out), 32'(x.b));
      chk("word_done", 32'(bus.word_done), 32'(x.d));
      if (x.d) begin
        if (wq.size() > 0) begin
          qexp  = wq.pop_front();
          qpend = 1'b1;
        end
      end
    end else begin
      chk("idle_en", 32'(bus.ser_en), 32'd0);
      chk("idle_out", 32'(bus.ser_out), 32'd0);
      chk("idle_done", 32'(bus.word_done), 32'd0);
    end
    busy = (k >= acc_e) && (k < start_e);
    chk("load_ready", 32'(bus.load_ready),
        32'(!rst && !busy));
    if (rst) begin
      eq.delete();
      wq.delete();
      acc_e    = -1;
      start_e  = -1;
      last_end = 0;
    end else if (bus.load_valid && bus.load_ready) begin
      ne = k + 1;
      ns = (ne + 1 > last_end + 1) ? ne + 1 : last_end + 1;
      for (int i = 0; i < W; i++) begin
        x.e = ns + i;
        x.b = bus.load_data[i];
        x.d = (i == W - 1);
        eq.push_back(x);
      end
      wq.push_back(bus.load_data);
      last_end = ns + W - 1;
      acc_e    = ne;
      start_e  = ns;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [W-1:0] w);
    bit r;
    int n;
    n = 0;
    bus.load_valid = 1'b1;
    bus.load_data  = w;
    do begin
      @(negedge clk);
      r = bus.load_ready;
      tick();
      n++;
    end while (!r && n < 50);
    if (!r) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got=busy want=ready");
    end
    bus.load_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running want=done");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    idle(3);
    rst = 1'b0;
    tick();

    send(4'b1011);
    idle(8);

    send(4'hA);
    send(4'h5);
    idle(10);

    send(4'h7);
    send(4'h2);
    bus.load_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.load_data = W'($urandom);
      tick();
    end
    bus.load_valid = 1'b0;
    idle(10);

    send(4'h3);
    idle(W + 6);
    send(4'hC);
    idle(8);

    send(4'hF);
    send(4'h6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle(2);
    send(4'h9);
    idle(8);

    for (int i = 0; i < 400; i++) begin
      rst            = ($urandom_range(0, 63) == 0);
      bus.load_valid = ($urandom_range(0, 3) != 0);
      bus.load_data  = W'($urandom);
      tick();
    end
    rst            = 1'b0;
    bus.load_valid = 1'b0;
    idle(14);

    chk("drained", 32'(eq.size() + wq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
